// File: rtl/axa_pkg.sv
// Shared AXA pipeline definitions: word width, default undo depth, undo entry type.
package axa_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned UNDO_DEPTH = 16;

  typedef logic [WORD_W-1:0] undo_entry_t;

endpackage

// File: rtl/undo_ram.sv
// Undo ring storage: one sync write port, async peek read, registered pop read.
module undo_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] peek_addr,
  output logic [WIDTH-1:0] peek_data,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign peek_data = mem[peek_addr];

  // Read-before-write on the same edge gives replace-top its old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/undo_stack.sv
// Parametrised ring-buffer undo stack with count, status, sticky error flags.
// Full policy: define UNDO_STACK_OVWR_EN to overwrite the oldest entry on a full push.
module undo_stack
  import axa_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = UNDO_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic [PTR_W-1:0] peek_off,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_valid,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf,
  input  logic             err_clr
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] sp_n;
  logic [PTR_W:0]   count_n;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] peek_addr;
  logic             we;
  logic [PTR_W-1:0] waddr;
  logic             rd_en;
  logic             set_ovf;
  logic             set_unf;

  assign top_ptr    = sp - PTR_W'(1);
  assign peek_addr  = sp - peek_off - PTR_W'(1);
  assign peek_valid = ((PTR_W+1)'(peek_off) < count);

  // Next pointer/count, RAM strobes and error-set events for this cycle.
  always_comb begin
    sp_n    = sp;
    count_n = count;
    we      = 1'b0;
    waddr   = sp;
    rd_en   = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (push && pop) begin
      if (empty) begin
        set_unf = 1'b1;
        we      = 1'b1;
        sp_n    = sp + PTR_W'(1);
        count_n = (PTR_W+1)'(1);
      end else begin
        rd_en = 1'b1;
        we    = 1'b1;
        waddr = top_ptr;
      end
    end else if (pop) begin
      if (empty) begin
        set_unf = 1'b1;
      end else begin
        rd_en   = 1'b1;
        sp_n    = top_ptr;
        count_n = count - (PTR_W+1)'(1);
      end
    end else if (push) begin
      if (full) begin
        set_ovf = 1'b1;
`ifdef UNDO_STACK_OVWR_EN
        // Ring semantics: overwrite oldest, count saturates at DEPTH.
        we   = 1'b1;
        sp_n = sp + PTR_W'(1);
`endif
      end else begin
        we      = 1'b1;
        sp_n    = sp + PTR_W'(1);
        count_n = count + (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp        <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      sp        <= sp_n;
      count     <= count_n;
      pop_valid <= pop;
      full      <= (count_n == CNT_FULL);
      empty     <= (count_n == '0);
      // Setting event beats a simultaneous clear.
      ovf       <= set_ovf | (ovf & ~err_clr);
      unf       <= set_unf | (unf & ~err_clr);
    end
  end

  undo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .waddr     (waddr),
    .wdata     (push_data),
    .peek_addr (peek_addr),
    .peek_data (peek_data),
    .rd_en     (rd_en),
    .rd_addr   (top_ptr),
    .rd_data   (pop_data)
  );

endmodule

// File: tb/tb_undo_stack.sv
// Self-checking bench for undo_stack (DEPTH=4) against a queue-based stack model.
module tb_undo_stack;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned PW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic [W-1:0]  push_data;
  logic          pop;
  logic [W-1:0]  pop_data;
  logic          pop_valid;
  logic [PW-1:0] peek_off;
  logic [W-1:0]  peek_data;
  logic          peek_valid;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          unf;
  logic          err_clr;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_pd;
  bit           m_pv;
  bit           m_ovf;
  bit           m_unf;

  undo_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .pop_data   (pop_data),
    .pop_valid  (pop_valid),
    .peek_off   (peek_off),
    .peek_data  (peek_data),
    .peek_valid (peek_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ovf        (ovf),
    .unf        (unf),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pd  = '0;
    m_pv  = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Stack semantics as a queue: back is top, front is oldest.
  task automatic model_step(input bit ps, input logic [W-1:0] d, input bit pp, input bit clr);
    bit was_empty;
    was_empty = (q.size() == 0);
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    m_pv = pp;
    if (ps && pp) begin
      if (was_empty) begin
        m_unf = 1'b1;
        q.push_back(d);
      end else begin
        m_pd = q[q.size()-1];
        q[q.size()-1] = d;
      end
    end else if (pp) begin
      if (was_empty) m_unf = 1'b1;
      else           m_pd = q.pop_back();
    end else if (ps) begin
      if (q.size() == int'(D)) begin
        m_ovf = 1'b1;
`ifdef UNDO_STACK_OVWR_EN
        void'(q.pop_front());
        q.push_back(d);
`endif
      end else begin
        q.push_back(d);
      end
    end
  endtask

  task automatic check_status();
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == int'(D)));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("pop_valid", 32'(pop_valid), 32'(m_pv));
    check("pop_data", 32'(pop_data), 32'(m_pd));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("unf", 32'(unf), 32'(m_unf));
  endtask

  task automatic check_all();
    check_status();
    for (int k = 0; k < int'(D); k++) begin
      peek_off = PW'(k);
      #1;
      check("peek_valid", 32'(peek_valid), 32'(k < q.size()));
      if (k < q.size()) check("peek_data", 32'(peek_data), 32'(q[q.size()-1-k]));
    end
  endtask

  task automatic step(input bit ps, input logic [W-1:0] d, input bit pp, input bit clr);
    push      = ps;
    push_data = d;
    pop       = pp;
    err_clr   = clr;
    @(posedge clk);
    model_step(ps, d, pp, clr);
    #1;
    check_all();
  endtask

  // Reset asserted between edges; state must clear before the next edge.
  task automatic async_reset();
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    reset   = 1'b1;
    #1;
    model_reset();
    check_status();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    err_clr   = 1'b0;
    push_data = '0;
    peek_off  = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    reset = 1'b0;

    // Push three, pop three plus one on empty.
    step(1, 16'h1111, 0, 0);
    step(1, 16'h2222, 0, 0);
    step(1, 16'h3333, 0, 0);
    repeat (4) step(0, '0, 1, 0);

    // Clear alone, then clear racing a pop on empty.
    step(0, '0, 0, 1);
    step(0, '0, 1, 1);
    step(0, '0, 0, 0);

    // Overfill a 4-deep stack.
    async_reset();
    for (int i = 1; i <= 5; i++) step(1, W'(i), 0, 0);
    step(0, '0, 0, 1);

    // Replace-top when full, then on a single entry.
    step(1, 16'hCAFE, 1, 0);
    async_reset();
    step(1, 16'hAAAA, 0, 0);
    step(1, 16'hBBBB, 1, 0);
    step(1, 16'h7777, 1, 0);

    // Push then asynchronous reset mid-cycle.
    step(1, 16'h5A5A, 0, 0);
    async_reset();
    step(0, '0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        async_reset();
      end else begin
        step(bit'($urandom_range(0, 1)), W'($urandom()), ($urandom_range(0, 9) < 4),
             ($urandom_range(0, 9) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/undo_stack.md
# undo_stack

Parametrised ring-buffer undo stack for the AXA pipeline, generalising the processor's fixed 16-entry undo array. Stage 2 pushes on forward execution of pushing instructions, pops on reverse execution, and reads arbitrary depth offsets for undo-type operands. The block adds a count, full/empty status, sticky error flags, simultaneous push/pop and a configurable full policy, none of which the inline array has.

## Interface
- WIDTH, 16, entry width in bits (AXA word)
- DEPTH, 16, entry count; power of two, 2..256
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; one clock domain only
- push  input  1  push push_data this cycle
- push_data  input  WIDTH  value to push
- pop  input  1  pop top entry this cycle
- pop_data  output  WIDTH  registered popped value
- pop_valid  output  1  pop_data updated this cycle (one-cycle pulse)
- peek_off  input  PTR_W  depth offset, 0 = top
- peek_data  output  WIDTH  combinational mem[sp - peek_off - 1]
- peek_valid  output  1  peek_off < count
- count  output  PTR_W+1  occupied entries, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- ovf  output  1  sticky: push lost or overwrote data
- unf  output  1  sticky: pop on empty
- err_clr  input  1  synchronous clear of ovf/unf

## Operation
- Storage is a DEPTH-entry ring. sp is a PTR_W-bit write pointer that wraps modulo DEPTH. The top entry is mem[sp-1].
- Push only: mem[sp] <= push_data, sp <= sp+1, count <= count+1.
- Pop only, not empty: pop_data <= mem[sp-1], sp <= sp-1, count <= count-1, pop_valid <= 1.
- Pop on empty: sp, count and pop_data are unchanged. unf <= 1. pop_valid <= 1. pop_data keeps its previous value.
- Push and pop together, not empty: pop_data <= old mem[sp-1], and mem[sp-1] <= push_data. sp and count are unchanged. pop_valid <= 1.
- Push and pop together, empty: treated as a pop on empty followed by a push. unf <= 1, pop_valid <= 1, pop_data is unchanged. Then mem[sp] <= push_data, sp <= sp+1, count <= 1.
- Push when full: behaviour depends on the Configuration macro.
- All peek and pointer arithmetic is modulo DEPTH, computed at PTR_W bits.
- peek_data is defined only when peek_valid = 1. Otherwise its value is unspecified, but it is the raw ring contents and never X once written.
- err_clr clears ovf and unf. If err_clr and a setting event occur in the same cycle, the setting event wins.

## Timing
- Reset values: sp = 0, count = 0, pop_data = 0, pop_valid = 0, ovf = 0, unf = 0, full = 0, empty = 1. Ring contents are not reset.
- Reset asserted mid-operation aborts any in-flight push or pop. The state returns to the reset values immediately, with no clock needed.
- A push is visible to peek, count, full and empty in the cycle after the edge that samples it.
- pop_data and pop_valid appear one cycle after pop is sampled. pop_valid drops in the next cycle unless pop is still asserted.
- peek_data has zero-cycle latency from peek_off and from the current state.
- Back-to-back pushes and pops are allowed every cycle with no bubbles.

## Configuration
- UNDO_STACK_OVWR_EN defined:
  - Push when full overwrites the oldest entry (ring semantics).
  - sp advances, count stays at DEPTH, ovf <= 1.
- UNDO_STACK_OVWR_EN undefined:
  - Push when full is dropped; memory, sp and count are unchanged.
  - ovf <= 1.
- Push and pop together when full is not a full-push. It follows the replace-top rule in both builds.

## Structure
- Shared package axa_pkg holds:
  - WORD_W = 16
  - the default undo depth UNDO_DEPTH = 16
  - the undo entry typedef
- Sub-module undo_ram: DEPTH x WIDTH array, one synchronous write port, one asynchronous read port for peek, one synchronous read port for pop.
- Pointer, count, flags and the full-policy logic live in undo_stack.

## Test plan
- After reset, push 0x1111, 0x2222, 0x3333 -> count = 3; peek_off 0/1/2 returns 0x3333/0x2222/0x1111; peek_off 3 gives peek_valid = 0.
- Pop three times, then pop once more -> pop_data 0x3333, 0x2222, 0x1111 on successive cycles with pop_valid high. Fourth pop: unf = 1, pop_data stays 0x1111, count = 0, empty = 1.
- DEPTH = 4: push 1..5.
  - With UNDO_STACK_OVWR_EN: count = 4, ovf = 1, peek_off 3 = 2.
  - Without UNDO_STACK_OVWR_EN: peek_off 0 = 4, peek_off 3 = 1.
- Stack holds 0xAAAA; assert push (0xBBBB) and pop together -> pop_data = 0xAAAA, count stays 1, peek_off 0 = 0xBBBB.
- Push 0x5A5A, then assert reset asynchronously between clock edges -> count = 0, empty = 1, pop_valid = 0, ovf = unf = 0 before the next edge.
- With unf set, assert err_clr alone -> unf = 0. Assert err_clr together with a pop on empty -> unf stays 1.
